clasificador_vc: RTL and testbench
==================================

# clasificador_vc

- Classifies the single ingress word stream into the two virtual-channel FIFOs VC0/VC1; it is the writer that fills the VC FIFOs drained by the routing arbiter.
- Pops the main ingress FIFO, captures the word one cycle later (registered FIFO read), and pushes it into VC0 or VC1 according to its class bit.
- Pop issue is gated by VC almost-full backpressure so no in-flight word is lost.
- Keeps per-VC push counters and a sticky overflow flag for verification and debug.

## Interface
- DATA_W, 6, word width (same as VC/D FIFOs)
- CLASS_BIT, 5, index of bit selecting the VC: 0 selects VC0, 1 selects VC1
- CNT_W, 8, width of push counters
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- main_data  in  DATA_W  main FIFO read data, valid the cycle after main_pop
- main_empty  in  1  main FIFO empty
- VC0_almost_full, VC1_almost_full  in  1  VC FIFO almost-full; threshold leaves at least 2 free slots
- VC0_full, VC1_full  in  1  VC FIFO full
- main_pop  out  1  pop request to main FIFO (combinational)
- VC0_push, VC1_push  out  1  registered push strobes
- VC0_data, VC1_data  out  DATA_W  registered write data
- cnt_VC0, cnt_VC1  out  CNT_W  accepted pushes per VC
- overflow_err  out  1  sticky: a push was suppressed because the target was full
- idle  out  1  high in state IDLE

## Operation
- main_pop = !reset & !main_empty & !VC0_almost_full & !VC1_almost_full. Both almost-fulls gate the pop because the class is unknown until the word is read.
- pop_delay register: pop_delay <= main_pop. When pop_delay = 1, main_data is a valid word.
- Class decode when pop_delay = 1:
  - main_data[CLASS_BIT] = 0: VC0_data <= main_data and VC0_push <= !VC0_full.
  - main_data[CLASS_BIT] = 1: the same for VC1.
  - Otherwise both push registers <= 0.
- Data registers hold their last value when no push occurs. Only one VC push is high in any cycle.
- If the target VC is full at capture, the push is suppressed, the word is dropped, and overflow_err <= 1. overflow_err clears only on reset.
- Counter cnt_VCx increments on each registered VCx_push and wraps from 2^CNT_W-1 to 0.
- FSM, 2-bit register:
  - IDLE to ACTIVE when !main_empty and neither almost_full is set.
  - IDLE to STALL when !main_empty and either almost_full is set.
  - ACTIVE to STALL when either almost_full is set.
  - ACTIVE to IDLE when main_empty and neither almost_full is set.
  - STALL to ACTIVE when both almost_fulls are clear and !main_empty.
  - STALL to IDLE when both are clear and main_empty.
  - Unused encoding goes to IDLE.
- The FSM is observable only through idle; it does not gate main_pop.
- Reset values: pop_delay 0, VC0_push/VC1_push 0, VC0_data/VC1_data 0, counters 0, overflow_err 0, state IDLE (idle = 1). main_pop is 0 while reset is high.
- Reset mid-operation: an in-flight word (pop_delay = 1 at the reset edge) is discarded with no push.

## Timing
- Latency: pop in cycle N, data captured at the edge ending N+1, push/data visible in N+2 for one cycle.
- Sustained throughput: 1 word/cycle while main is non-empty and there is no backpressure.
- Up to 2 words can be in flight after almost_full rises; the almost_full margin of 2 is required for lossless operation.
- main_empty and the almost_fulls are sampled combinationally in the same cycle as main_pop. Simultaneous almost_full rise and main non-empty gives no pop that cycle.

## Configuration
- CLASIFICADOR_CONTADORES_EN defined: cnt_VC0/cnt_VC1 counters are implemented as described.
- CLASIFICADOR_CONTADORES_EN undefined: counter registers are omitted and cnt_VC0/cnt_VC1 are tied to 0. All other behaviour is identical.

## Test plan
- Reset: hold reset 2 cycles with main non-empty -> main_pop = 0, all pushes 0, data 0, counters 0, idle = 1.
- Stream: main preloaded with 6'h05, 6'h25, 6'h0A, 6'h3F; pops in cycles 0-3 -> VC0_push with 05 in cycle 2, VC1_push with 25 in 3, VC0 with 0A in 4, VC1 with 3F in 5; cnt_VC0 = 2, cnt_VC1 = 2.
- Backpressure: assert VC1_almost_full in cycle 1 of a continuous stream -> main_pop low from cycle 1, at most 2 further pushes, state STALL, idle = 0; deassert -> pops resume the same cycle, state ACTIVE.
- Overflow: VC0_full = 1 when word 6'h01 reaches capture -> no VC0_push, overflow_err = 1 and stays 1 until reset.
- Wrap: 256 VC0-class words -> cnt_VC0 returns to 0; with the macro undefined the counters stay 0 throughout.
- Mid-flight reset: assert reset the cycle after a pop -> no push follows, all outputs at reset values next cycle.

Source files
------------

// File: rtl/clasificador_vc_if.sv
// Ingress-to-VC bus: main FIFO read port plus the VC0/VC1 FIFO write ports and status.
// master = classifier side, slave = FIFO/environment side.
interface clasificador_vc_if #(
  parameter int DATA_W = 6
);
  logic [DATA_W-1:0] main_data;
  logic              main_empty;
  logic              main_pop;
  logic              VC0_almost_full;
  logic              VC1_almost_full;
  logic              VC0_full;
  logic              VC1_full;
  logic              VC0_push;
  logic              VC1_push;
  logic [DATA_W-1:0] VC0_data;
  logic [DATA_W-1:0] VC1_data;

  modport master (
    input  main_data, main_empty,
    input  VC0_almost_full, VC1_almost_full, VC0_full, VC1_full,
    output main_pop,
    output VC0_push, VC1_push, VC0_data, VC1_data
  );

  modport slave (
    output main_data, main_empty,
    output VC0_almost_full, VC1_almost_full, VC0_full, VC1_full,
    input  main_pop,
    input  VC0_push, VC1_push, VC0_data, VC1_data
  );
endinterface

// File: rtl/clasificador_vc.sv
// Splits the ingress word stream into VC0/VC1 by class bit; counters under CLASIFICADOR_CONTADORES_EN.
// Pop to push is 2 cycles; pops stop while either VC is almost full (2 words may still land).
module clasificador_vc #(
  parameter int DATA_W    = 6,
  parameter int CLASS_BIT = 5,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  clasificador_vc_if.master   vc_bus,
  output logic [CNT_W-1:0]    cnt_VC0,
  output logic [CNT_W-1:0]    cnt_VC1,
  output logic                overflow_err,
  output logic                idle
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACTIVE = 2'b01;
  localparam logic [1:0] STALL  = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       pop_delay;
  logic       any_af;
  logic       word_vc;

  // The class is unknown before the read, so either almost-full blocks the pop.
  assign any_af          = vc_bus.VC0_almost_full | vc_bus.VC1_almost_full;
  assign vc_bus.main_pop = !reset && !vc_bus.main_empty && !any_af;
  assign word_vc         = vc_bus.main_data[CLASS_BIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_delay       <= 1'b0;
      vc_bus.VC0_push <= 1'b0;
      vc_bus.VC1_push <= 1'b0;
      vc_bus.VC0_data <= '0;
      vc_bus.VC1_data <= '0;
      overflow_err    <= 1'b0;
    end else begin
      pop_delay       <= vc_bus.main_pop;
      vc_bus.VC0_push <= 1'b0;
      vc_bus.VC1_push <= 1'b0;
      if (pop_delay) begin
        if (!word_vc) begin
          vc_bus.VC0_data <= vc_bus.main_data;
          vc_bus.VC0_push <= !vc_bus.VC0_full;
          if (vc_bus.VC0_full) overflow_err <= 1'b1;
        end else begin
          vc_bus.VC1_data <= vc_bus.main_data;
          vc_bus.VC1_push <= !vc_bus.VC1_full;
          if (vc_bus.VC1_full) overflow_err <= 1'b1;
        end
      end
    end
  end

`ifdef CLASIFICADOR_CONTADORES_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_VC0 <= '0;
      cnt_VC1 <= '0;
    end else begin
      if (vc_bus.VC0_push) cnt_VC0 <= cnt_VC0 + CNT_W'(1);
      if (vc_bus.VC1_push) cnt_VC1 <= cnt_VC1 + CNT_W'(1);
    end
  end
`else
  assign cnt_VC0 = '0;
  assign cnt_VC1 = '0;
`endif

  // Status-only FSM; main_pop does not depend on it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!vc_bus.main_empty) state_nxt = any_af ? STALL : ACTIVE;
      end
      ACTIVE: begin
        if (any_af)                 state_nxt = STALL;
        else if (vc_bus.main_empty) state_nxt = IDLE;
      end
      STALL: begin
        if (!any_af) state_nxt = vc_bus.main_empty ? IDLE : ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign idle = (state == IDLE);

endmodule

// File: tb/tb_clasificador_vc.sv
// Scoreboard bench for clasificador_vc: a queue models the main FIFO, expected pushes are
// queued at load time and matched against VC0/VC1 push strobes.
module tb_clasificador_vc;
  localparam int DATA_W    = 6;
  localparam int CLASS_BIT = 5;
  localparam int CNT_W     = 8;
`ifdef CLASIFICADOR_CONTADORES_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clasificador_vc_if #(.DATA_W(DATA_W)) bus ();
  logic [CNT_W-1:0] cnt_VC0;
  logic [CNT_W-1:0] cnt_VC1;
  logic             overflow_err;
  logic             idle;

  clasificador_vc #(.DATA_W(DATA_W), .CLASS_BIT(CLASS_BIT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .vc_bus       (bus),
    .cnt_VC0      (cnt_VC0),
    .cnt_VC1      (cnt_VC1),
    .overflow_err (overflow_err),
    .idle         (idle)
  );

  logic [DATA_W-1:0] main_q[$];
  logic [DATA_W-1:0] load_q[$];
  logic [DATA_W:0]   exp_q[$];
  logic              flush_req = 1'b1;
  int                checks = 0;
  int                passed = 0;
  int                push_total = 0;

  // Main FIFO model with registered read data.
  always @(posedge clk) begin
    if (flush_req) begin
      main_q.delete();
    end else if (bus.main_pop && main_q.size() > 0) begin
      bus.main_data <= main_q.pop_front();
    end
    while (load_q.size() > 0) main_q.push_back(load_q.pop_front());
    bus.main_empty <= (main_q.size() == 0);
  end

  task automatic cycle();
    logic [DATA_W:0] exp_e;
    logic [DATA_W:0] got;
    @(negedge clk);
    if (!reset && (bus.VC0_push || bus.VC1_push)) begin
      checks++;
      push_total++;
      if (bus.VC0_push && bus.VC1_push) begin
        $display("FAIL push_onehot: both VC0_push and VC1_push high, required only one");
      end else if (exp_q.size() == 0) begin
        $display("FAIL unexpected_push: vc0=%b vc1=%b d0=%h d1=%h, required no push",
                 bus.VC0_push, bus.VC1_push, bus.VC0_data, bus.VC1_data);
      end else begin
        exp_e = exp_q.pop_front();
        got   = bus.VC1_push ? {1'b1, bus.VC1_data} : {1'b0, bus.VC0_data};
        if (got !== exp_e)
          $display("FAIL push_data: got vc%0d/%h, required vc%0d/%h",
                   got[DATA_W], got[DATA_W-1:0], exp_e[DATA_W], exp_e[DATA_W-1:0]);
        else
          passed++;
      end
    end
  endtask

  task automatic load(input logic [DATA_W-1:0] w, input bit expect_push);
    load_q.push_back(w);
    if (expect_push) exp_q.push_back({w[CLASS_BIT], w});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_req = 1'b1;
    load_q.delete();
    exp_q.delete();
    bus.VC0_almost_full = 1'b0;
    bus.VC1_almost_full = 1'b0;
    bus.VC0_full = 1'b0;
    bus.VC1_full = 1'b0;
    cycle();
    cycle();
    flush_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      cycle();
      if (exp_q.size() == 0 && load_q.size() == 0 && bus.main_empty === 1'b1 &&
          !bus.VC0_push && !bus.VC1_push)
        done = 1'b1;
    end
    checks++;
    if (!done) $display("FAIL %s_drain: %0d pushes outstanding, required 0", name, exp_q.size());
    else passed++;
    repeat (3) cycle();
  endtask

  // Waits until main reports non-empty; returns ok=0 on timeout.
  task automatic wait_nonempty(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      cycle();
      if (bus.main_empty === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) $display("FAIL %s_wait: main_empty stayed %b, required 0", name, bus.main_empty);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    load(6'h11, 1'b1);
    load(6'h2A, 1'b1);
    cycle();
    cycle();
    #1;
    checks++; if (bus.main_pop !== 1'b0) $display("FAIL rst_pop: got %b required 0", bus.main_pop); else passed++;
    checks++; if ({bus.VC0_push, bus.VC1_push} !== 2'b00) $display("FAIL rst_push: got %b required 00", {bus.VC0_push, bus.VC1_push}); else passed++;
    checks++; if ({bus.VC0_data, bus.VC1_data} !== '0) $display("FAIL rst_data: got %h/%h required 0/0", bus.VC0_data, bus.VC1_data); else passed++;
    checks++; if ({cnt_VC0, cnt_VC1} !== '0) $display("FAIL rst_cnt: got %0d/%0d required 0/0", cnt_VC0, cnt_VC1); else passed++;
    checks++; if (overflow_err !== 1'b0) $display("FAIL rst_ovf: got %b required 0", overflow_err); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b required 1", idle); else passed++;
    reset = 1'b0;
    drain("rst");
  endtask

  task automatic test_stream();
    bit ok;
    bit [7:0] e0 = 8'b0001_0100;
    bit [7:0] e1 = 8'b0010_1000;
    do_reset();
    load(6'h05, 1'b1);
    load(6'h25, 1'b1);
    load(6'h0A, 1'b1);
    load(6'h3F, 1'b1);
    wait_nonempty("stream", ok);
    if (!ok) return;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (bus.main_pop !== (c < 4)) $display("FAIL stream_pop c%0d: got %b required %b", c, bus.main_pop, (c < 4)); else passed++;
      checks++; if (bus.VC0_push !== e0[c]) $display("FAIL stream_vc0 c%0d: got %b required %b", c, bus.VC0_push, e0[c]); else passed++;
      checks++; if (bus.VC1_push !== e1[c]) $display("FAIL stream_vc1 c%0d: got %b required %b", c, bus.VC1_push, e1[c]); else passed++;
      if (c == 2) begin
        checks++; if (idle !== 1'b0) $display("FAIL stream_active: idle got %b required 0", idle); else passed++;
      end
      if (c == 7) begin
        checks++; if (idle !== 1'b1) $display("FAIL stream_idle: idle got %b required 1", idle); else passed++;
        checks++; if (cnt_VC0 !== (CNT_EN ? 8'd2 : 8'd0)) $display("FAIL stream_cnt0: got %0d required %0d", cnt_VC0, (CNT_EN ? 2 : 0)); else passed++;
        checks++; if (cnt_VC1 !== (CNT_EN ? 8'd2 : 8'd0)) $display("FAIL stream_cnt1: got %0d required %0d", cnt_VC1, (CNT_EN ? 2 : 0)); else passed++;
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit popped = 1'b0;
    int snap;
    do_reset();
    for (int i = 0; i < 8; i++) load(DATA_W'(((i % 2) << CLASS_BIT) | (i + 1)), 1'b1);
    wait_nonempty("bp", ok);
    if (!ok) return;
    cycle();
    bus.VC1_almost_full = 1'b1;
    #1;
    checks++; if (bus.main_pop !== 1'b0) $display("FAIL bp_pop_gate: got %b required 0", bus.main_pop); else passed++;
    snap = push_total;
    for (int k = 0; k < 5; k++) begin
      cycle();
      #1;
      if (bus.main_pop !== 1'b0) popped = 1'b1;
    end
    checks++; if (popped) $display("FAIL bp_pop_held: main_pop rose during stall, required 0"); else passed++;
    checks++; if (push_total - snap > 2) $display("FAIL bp_inflight: got %0d pushes required <= 2", push_total - snap); else passed++;
    checks++; if (idle !== 1'b0) $display("FAIL bp_stall_idle: got %b required 0", idle); else passed++;
    bus.VC1_almost_full = 1'b0;
    #1;
    checks++; if (bus.main_pop !== 1'b1) $display("FAIL bp_resume: got %b required 1", bus.main_pop); else passed++;
    cycle();
    checks++; if (idle !== 1'b0) $display("FAIL bp_active_idle: got %b required 0", idle); else passed++;
    drain("bp");
    checks++; if (idle !== 1'b1) $display("FAIL bp_end_idle: got %b required 1", idle); else passed++;
  endtask

  task automatic test_overflow();
    int snap;
    do_reset();
    bus.VC0_full = 1'b1;
    snap = push_total;
    load(6'h01, 1'b0);
    repeat (6) cycle();
    checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_set: got %b required 1", overflow_err); else passed++;
    checks++; if (push_total !== snap) $display("FAIL ovf_nopush: got %0d pushes required 0", push_total - snap); else passed++;
    bus.VC0_full = 1'b0;
    load(6'h02, 1'b1);
    drain("ovf");
    checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", overflow_err); else passed++;
    do_reset();
    #1;
    checks++; if (overflow_err !== 1'b0) $display("FAIL ovf_clear: got %b required 0", overflow_err); else passed++;
  endtask

  task automatic test_wrap();
    int snap;
    do_reset();
    snap = push_total;
    for (int i = 0; i < 200; i++) load(DATA_W'(i % 32), 1'b1);
    drain("wrap_a");
    checks++; if (cnt_VC0 !== (CNT_EN ? 8'd200 : 8'd0)) $display("FAIL wrap_mid: got %0d required %0d", cnt_VC0, (CNT_EN ? 200 : 0)); else passed++;
    for (int i = 200; i < 256; i++) load(DATA_W'(i % 32), 1'b1);
    drain("wrap_b");
    checks++; if (push_total - snap !== 256) $display("FAIL wrap_pushes: got %0d required 256", push_total - snap); else passed++;
    checks++; if (cnt_VC0 !== 8'd0) $display("FAIL wrap_cnt0: got %0d required 0", cnt_VC0); else passed++;
    checks++; if (cnt_VC1 !== 8'd0) $display("FAIL wrap_cnt1: got %0d required 0", cnt_VC1); else passed++;
  endtask

  task automatic test_midflight_reset();
    bit ok;
    int snap;
    do_reset();
    load(6'h13, 1'b1);
    drain("mid_pre");
    load(6'h2C, 1'b0);
    wait_nonempty("mid", ok);
    if (!ok) return;
    #1;
    checks++; if (bus.main_pop !== 1'b1) $display("FAIL mid_pop: got %b required 1", bus.main_pop); else passed++;
    cycle();
    reset = 1'b1;
    snap = push_total;
    cycle();
    #1;
    checks++; if ({bus.VC0_push, bus.VC1_push} !== 2'b00) $display("FAIL mid_push: got %b required 00", {bus.VC0_push, bus.VC1_push}); else passed++;
    checks++; if ({bus.VC0_data, bus.VC1_data} !== '0) $display("FAIL mid_data: got %h/%h required 0/0", bus.VC0_data, bus.VC1_data); else passed++;
    checks++; if ({cnt_VC0, cnt_VC1} !== '0) $display("FAIL mid_cnt: got %0d/%0d required 0/0", cnt_VC0, cnt_VC1); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL mid_idle: got %b required 1", idle); else passed++;
    checks++; if (bus.main_pop !== 1'b0) $display("FAIL mid_pop_rst: got %b required 0", bus.main_pop); else passed++;
    reset = 1'b0;
    repeat (4) cycle();
    checks++; if (push_total !== snap) $display("FAIL mid_discard: got %0d pushes required 0", push_total - snap); else passed++;
  endtask

  initial begin
    bus.VC0_almost_full = 1'b0;
    bus.VC1_almost_full = 1'b0;
    bus.VC0_full = 1'b0;
    bus.VC1_full = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_midflight_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
